// File: rtl/cve2_mac_result_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cve2_mac_result_unit_if                                            |
// | Issue, multiplier, adder and result signals of the MAC unit.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface cve2_mac_result_unit_if #(
   parameter int WIDTH = 32
);
   logic             mac_start_i;
   logic             mac_kill_i;
   logic [WIDTH-1:0] op_a_i;
   logic [WIDTH-1:0] op_b_i;
   logic [WIDTH-1:0] op_c_i;
   logic             mul_req_o;
   logic [WIDTH-1:0] mul_op_a_o;
   logic [WIDTH-1:0] mul_op_b_o;
   logic             mul_valid_i;
   logic [WIDTH-1:0] mul_result_i;
   logic             add_req_o;
   logic [WIDTH-1:0] add_op_a_o;
   logic [WIDTH-1:0] add_op_b_o;
   logic [WIDTH-1:0] add_result_i;
   logic             stall_o;
   logic             busy_o;
   logic [WIDTH-1:0] result_o;
   logic             result_valid_o;
   logic             overflow_o;

   // The MAC unit is the responder on this bundle.
   modport slave (
      input  mac_start_i, mac_kill_i, op_a_i, op_b_i, op_c_i,
             mul_valid_i, mul_result_i, add_result_i,
      output mul_req_o, mul_op_a_o, mul_op_b_o, add_req_o, add_op_a_o,
             add_op_b_o, stall_o, busy_o, result_o, result_valid_o, overflow_o
   );

   modport master (
      output mac_start_i, mac_kill_i, op_a_i, op_b_i, op_c_i,
             mul_valid_i, mul_result_i, add_result_i,
      input  mul_req_o, mul_op_a_o, mul_op_b_o, add_req_o, add_op_a_o,
             add_op_b_o, stall_o, busy_o, result_o, result_valid_o, overflow_o
   );
endinterface
`default_nettype wire

// File: rtl/cve2_mac_result_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cve2_mac_result_unit                                               |
// | Two-step MAC sequencer: shared multiply, then shared add.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cve2_mac_result_unit #(
   parameter int WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   cve2_mac_result_unit_if.slave bus
);
   localparam int MSB = WIDTH - 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_ADD  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e           r_state;
   state_e           w_state_next;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [WIDTH-1:0] r_op_c;
   logic [WIDTH-1:0] r_product;
   logic [WIDTH-1:0] r_result;
   logic             r_overflow;
   logic             w_start;
   logic             w_add_ovf;

   assign w_start   = bus.mac_start_i && !bus.mac_kill_i;
   assign w_add_ovf = (r_product[MSB] == r_op_c[MSB]) &&
                      (bus.add_result_i[MSB] != r_product[MSB]);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_op_c     <= '0;
         r_product  <= '0;
         r_result   <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (r_state == S_IDLE && w_start) begin
            r_op_a <= bus.op_a_i;
            r_op_b <= bus.op_b_i;
            r_op_c <= bus.op_c_i;
         end
         // A kill in the same cycle discards the product or sum.
         if (r_state == S_MUL && bus.mul_valid_i && !bus.mac_kill_i) begin
            r_product <= bus.mul_result_i;
         end
         if (r_state == S_ADD && !bus.mac_kill_i) begin
            r_result   <= bus.add_result_i;
            r_overflow <= w_add_ovf;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (w_start) w_state_next = S_MUL;
         S_MUL: begin
            if (bus.mac_kill_i)       w_state_next = S_IDLE;
            else if (bus.mul_valid_i) w_state_next = S_ADD;
         end
         S_ADD:   w_state_next = bus.mac_kill_i ? S_IDLE : S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.mul_req_o      = 1'b0;
      bus.mul_op_a_o     = '0;
      bus.mul_op_b_o     = '0;
      bus.add_req_o      = 1'b0;
      bus.add_op_a_o     = '0;
      bus.add_op_b_o     = '0;
      bus.stall_o        = 1'b0;
      bus.result_valid_o = 1'b0;
      case (r_state)
         S_IDLE: bus.stall_o = w_start;
         S_MUL: begin
            bus.mul_req_o  = 1'b1;
            bus.mul_op_a_o = r_op_a;
            bus.mul_op_b_o = r_op_b;
            bus.stall_o    = 1'b1;
         end
         S_ADD: begin
            bus.add_req_o  = 1'b1;
            bus.add_op_a_o = r_product;
            bus.add_op_b_o = r_op_c;
            bus.stall_o    = 1'b1;
         end
         S_DONE:  bus.result_valid_o = 1'b1;
         default: bus.stall_o = 1'b0;
      endcase
   end

   assign bus.busy_o     = (r_state != S_IDLE);
   assign bus.result_o   = r_result;
   assign bus.overflow_o = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_cve2_mac_result_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cve2_mac_result_unit                                            |
// | Directed bench with a result scoreboard for the MAC unit.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_cve2_mac_result_unit;
   localparam int WIDTH = 32;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;
   exp_t sb[$];

   cve2_mac_result_unit_if #(.WIDTH(WIDTH)) bus ();

   cve2_mac_result_unit #(.WIDTH(WIDTH)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Environment models of the shared multiplier and ALU adder.
   assign bus.mul_result_i = bus.mul_op_a_o * bus.mul_op_b_o;
   assign bus.add_result_i = bus.add_op_a_o + bus.add_op_b_o;

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.result_valid_o) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_result", bus.result_o, e.res);
            chk("sb_overflow", {31'd0, bus.overflow_o}, {31'd0, e.ovf});
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_stall"}, {31'd0, bus.stall_o}, 32'd0);
      chk({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd0);
      chk({tag, "_mul_req"}, {31'd0, bus.mul_req_o}, 32'd0);
      chk({tag, "_add_req"}, {31'd0, bus.add_req_o}, 32'd0);
      chk({tag, "_mul_a"}, bus.mul_op_a_o, 32'd0);
      chk({tag, "_mul_b"}, bus.mul_op_b_o, 32'd0);
      chk({tag, "_add_a"}, bus.add_op_a_o, 32'd0);
      chk({tag, "_add_b"}, bus.add_op_b_o, 32'd0);
      chk({tag, "_result"}, bus.result_o, 32'd0);
      chk({tag, "_ovf"}, {31'd0, bus.overflow_o}, 32'd0);
      chk({tag, "_valid"}, {31'd0, bus.result_valid_o}, 32'd0);
   endtask

   // One MAC; mul_valid arrives in cycle lat (lat>=1) counted from start.
   task automatic mac(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] c, input int lat, input bit kill_done);
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] s;
      exp_t             e;
      p = a * b;
      s = p + c;
      e.res = s;
      e.ovf = (p[WIDTH-1] == c[WIDTH-1]) && (s[WIDTH-1] != p[WIDTH-1]);
      sb.push_back(e);
      @(negedge clk);
      bus.mac_start_i = 1'b1;
      bus.op_a_i = a; bus.op_b_i = b; bus.op_c_i = c;
      #1 chk("c0_stall", {31'd0, bus.stall_o}, 32'd1);
      chk("c0_busy", {31'd0, bus.busy_o}, 32'd0);
      for (int i = 1; i <= lat; i++) begin
         @(negedge clk);
         bus.mac_start_i = 1'b0;
         bus.op_a_i = '0; bus.op_b_i = '0; bus.op_c_i = '0;
         bus.mul_valid_i = (i == lat);
         #1 chk("mul_req", {31'd0, bus.mul_req_o}, 32'd1);
         chk("mul_op_a", bus.mul_op_a_o, a);
         chk("mul_op_b", bus.mul_op_b_o, b);
         chk("mul_stall", {31'd0, bus.stall_o}, 32'd1);
      end
      @(negedge clk);
      bus.mul_valid_i = 1'b0;
      #1 chk("add_req", {31'd0, bus.add_req_o}, 32'd1);
      chk("add_mul_req", {31'd0, bus.mul_req_o}, 32'd0);
      chk("add_op_a", bus.add_op_a_o, p);
      chk("add_op_b", bus.add_op_b_o, c);
      chk("add_stall", {31'd0, bus.stall_o}, 32'd1);
      @(negedge clk);
      bus.mac_kill_i = kill_done;
      #1 chk("done_valid", {31'd0, bus.result_valid_o}, 32'd1);
      chk("done_stall", {31'd0, bus.stall_o}, 32'd0);
      chk("done_req", {30'd0, bus.mul_req_o, bus.add_req_o}, 32'd0);
      @(negedge clk);
      bus.mac_kill_i = 1'b0;
      #1 chk("idle_busy", {31'd0, bus.busy_o}, 32'd0);
   endtask

   initial begin
      bus.mac_start_i = 1'b0;
      bus.mac_kill_i  = 1'b0;
      bus.op_a_i      = '0;
      bus.op_b_i      = '0;
      bus.op_c_i      = '0;
      bus.mul_valid_i = 1'b0;

      #12 chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Basic, slow multiplier, wrap and overflow.
      mac(32'd3, 32'd4, 32'd10, 1, 1'b0);
      chk("basic_result", bus.result_o, 32'd22);
      mac(32'd5, 32'd7, 32'd100, 5, 1'b0);
      mac(32'h0001_0000, 32'h0001_0000, 32'd5, 1, 1'b0);
      mac(32'h4000_0000, 32'd2, 32'h7FFF_FFFF, 2, 1'b0);
      chk("wrap_result", bus.result_o, 32'hFFFF_FFFF);
      chk("wrap_ovf", {31'd0, bus.overflow_o}, 32'd0);
      mac(32'd1, 32'h7FFF_FFFF, 32'd1, 1, 1'b0);
      chk("ovf_result", bus.result_o, 32'h8000_0000);
      chk("ovf_ovf", {31'd0, bus.overflow_o}, 32'd1);

      // Kill in MUL together with mul_valid.
      @(negedge clk);
      bus.mac_start_i = 1'b1;
      bus.op_a_i = 32'd9; bus.op_b_i = 32'd9; bus.op_c_i = 32'd9;
      @(negedge clk);
      bus.mac_start_i = 1'b0;
      bus.mac_kill_i = 1'b1;
      bus.mul_valid_i = 1'b1;
      #1 chk("kmul_req", {31'd0, bus.mul_req_o}, 32'd1);
      @(negedge clk);
      bus.mac_kill_i = 1'b0;
      bus.mul_valid_i = 1'b0;
      #1 chk("kmul_busy", {31'd0, bus.busy_o}, 32'd0);
      chk("kmul_result", bus.result_o, 32'h8000_0000);
      chk("kmul_ovf", {31'd0, bus.overflow_o}, 32'd1);
      @(negedge clk);
      #1 chk("kmul_valid", {31'd0, bus.result_valid_o}, 32'd0);

      // Kill in ADD.
      @(negedge clk);
      bus.mac_start_i = 1'b1;
      bus.op_a_i = 32'd2; bus.op_b_i = 32'd2; bus.op_c_i = 32'd2;
      @(negedge clk);
      bus.mac_start_i = 1'b0;
      bus.mul_valid_i = 1'b1;
      @(negedge clk);
      bus.mul_valid_i = 1'b0;
      bus.mac_kill_i = 1'b1;
      #1 chk("kadd_req", {31'd0, bus.add_req_o}, 32'd1);
      @(negedge clk);
      bus.mac_kill_i = 1'b0;
      #1 chk("kadd_busy", {31'd0, bus.busy_o}, 32'd0);
      chk("kadd_result", bus.result_o, 32'h8000_0000);
      chk("kadd_ovf", {31'd0, bus.overflow_o}, 32'd1);
      chk("kadd_valid", {31'd0, bus.result_valid_o}, 32'd0);

      // Kill in DONE still yields the pulse.
      mac(32'd6, 32'd6, 32'd6, 1, 1'b1);

      // Reset asserted in ADD.
      @(negedge clk);
      bus.mac_start_i = 1'b1;
      bus.op_a_i = 32'd11; bus.op_b_i = 32'd11; bus.op_c_i = 32'd11;
      @(negedge clk);
      bus.mac_start_i = 1'b0;
      bus.mul_valid_i = 1'b1;
      @(negedge clk);
      bus.mul_valid_i = 1'b0;
      #1 chk("rst_pre_add", {31'd0, bus.add_req_o}, 32'd1);
      rst_n = 1'b0;
      #1 chk_zero("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      mac(32'd6, 32'd7, 32'd8, 1, 1'b0);
      chk("post_rst_result", bus.result_o, 32'd50);

      // Start held high: one result every 4 cycles, start in DONE ignored.
      for (int i = 0; i < 3; i++) sb.push_back('{res: 32'd10, ovf: 1'b0});
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         bus.mac_start_i = 1'b1;
         bus.mul_valid_i = 1'b1;
         bus.op_a_i = 32'd2; bus.op_b_i = 32'd3; bus.op_c_i = 32'd4;
         #1 chk("b2b_valid", {31'd0, bus.result_valid_o}, {31'd0, (i % 4) == 3});
         chk("b2b_busy", {31'd0, bus.busy_o}, {31'd0, (i % 4) != 0});
      end
      @(negedge clk);
      bus.mac_start_i = 1'b0;
      bus.mul_valid_i = 1'b0;
      @(negedge clk);
      #1 chk("b2b_idle", {31'd0, bus.busy_o}, 32'd0);

      chk("sb_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/cve2_mac_result_unit.md
# cve2_mac_result_unit

Datapath-side responder for the two-step MAC sequence. It accepts a MAC issue from the ID stage, drives the shared multiplier and waits for its product. It then drives the shared ALU adder with product + accumulator, and returns one registered result with a one-cycle valid pulse. Its `stall_o` holds the ID stage for the whole operation, and a flush input aborts the sequence at any step.

## Interface
Parameters:
- `WIDTH`, default 32: operand, product and result width.

Ports (reset `rst_ni` is asynchronous, active-low; clock is `clk_i`):
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `mac_start_i` in 1: MAC instruction issued; sampled only in IDLE.
- `mac_kill_i` in 1: pipeline flush; aborts any in-flight MAC.
- `op_a_i` in WIDTH: multiplicand (rs1).
- `op_b_i` in WIDTH: multiplier (rs2).
- `op_c_i` in WIDTH: accumulator (rd old value).
- `mul_req_o` out 1: multiplier request.
- `mul_op_a_o` out WIDTH: multiplier operand A.
- `mul_op_b_o` out WIDTH: multiplier operand B.
- `mul_valid_i` in 1: multiplier result valid.
- `mul_result_i` in WIDTH: low WIDTH bits of the product.
- `add_req_o` out 1: ALU add step active.
- `add_op_a_o` out WIDTH: adder operand A.
- `add_op_b_o` out WIDTH: adder operand B.
- `add_result_i` in WIDTH: combinational adder sum, valid in the same cycle.
- `stall_o` out 1: hold the ID stage.
- `busy_o` out 1: state is not IDLE.
- `result_o` out WIDTH: registered MAC result.
- `result_valid_o` out 1: one-cycle result pulse.
- `overflow_o` out 1: signed overflow of the add step, registered with `result_o`.

## Operation
- **States:** IDLE, MUL, ADD, DONE; 2-bit encoding; any illegal encoding returns to IDLE.
- **IDLE:**
  - On `mac_start_i && !mac_kill_i`, latch `op_a_i`, `op_b_i`, `op_c_i` into internal registers and go to MUL.
  - Otherwise remain in IDLE.
- **MUL:**
  - `mul_req_o`=1; `mul_op_a_o`/`mul_op_b_o` come from the latched registers and are stable while the request is high.
  - On `mul_valid_i`, capture `mul_result_i` into the product register and go to ADD.
  - Otherwise wait; there is no timeout.
- **ADD:**
  - `add_req_o`=1, `add_op_a_o`=product register, `add_op_b_o`=latched accumulator.
  - Capture `add_result_i` into `result_o`.
  - `overflow_o` = (A[MSB]==B[MSB]) && (sum[MSB]!=A[MSB]).
  - Go to DONE.
- **DONE:** `result_valid_o`=1; go to IDLE.
- **Arithmetic:** product is truncated to WIDTH bits, sum wraps modulo 2^WIDTH, no saturation.
- **Idle outputs:** when not in their active state, `mul_op_*_o` and `add_op_*_o` are 0, as are `mul_req_o` and `add_req_o`.
- **`stall_o`:** 1 in MUL and ADD, and in IDLE when `mac_start_i && !mac_kill_i`. It is 0 in DONE so the instruction retires that cycle.
- **`busy_o`:** equals (state != IDLE).
- **Kill:**
  - `mac_kill_i` in MUL or ADD forces IDLE next cycle.
  - Neither `result_o` nor `overflow_o` is updated (a kill in ADD suppresses the capture), and no `result_valid_o` pulse is produced.
  - `mul_valid_i` arriving in the same cycle as the kill is discarded.
  - A kill in DONE does not suppress the pulse, since the result is already committed.
- **`mac_start_i` outside IDLE:** ignored.
- **`result_o` / `overflow_o` hold:** both keep their value until the next completed ADD.

## Timing
- **Reset:** state IDLE, and all latched and product registers 0. All outputs are 0: `result_o`, `overflow_o`, `result_valid_o`, `stall_o`, `busy_o`, `mul_req_o`, `add_req_o`, and all operand outputs.
- **Reset mid-operation:** returns to IDLE asynchronously with no result pulse.
- **Latency:**
  - Start sampled in cycle 0; MUL begins in cycle 1.
  - If `mul_valid_i` arrives in cycle k≥1, ADD is cycle k+1 and `result_valid_o` is in cycle k+2.
  - With a single-cycle multiplier (k=1), the result is valid 3 cycles after start.
- **Back-to-back:** the earliest next start is sampled in the cycle after DONE (IDLE).
- **Output paths:** `stall_o` is combinational from `mac_start_i`/`mac_kill_i` in IDLE. All other outputs decode from registered state only.

## Test plan
- **Basic MAC:** reset, then start with a=3, b=4, c=10 and `mul_valid_i` in cycle 1 → `mul_req_o` is high in cycle 1 only, the add step uses 12+10, and `result_o`=22 with a `result_valid_o` pulse in cycle 3. `stall_o` is high in cycles 0–2 and low in cycle 3.
- **Slow multiplier:** `mul_valid_i` arrives 4 cycles after the request → `mul_op_a_o`/`mul_op_b_o` stay stable throughout, and the valid pulse occurs exactly 2 cycles after `mul_valid_i`.
- **Wrap and overflow:** a=0x10000, b=0x10000 gives a product of 0. Then a=0x40000000, b=2, c=0x7FFFFFFF → sum is 0xFFFFFFFF and `overflow_o`=0. Then a=1, b=0x7FFFFFFF, c=1 → `result_o`=0x80000000 and `overflow_o`=1.
- **Kill:** kill in MUL together with `mul_valid_i` → IDLE next cycle, no pulse, `result_o` unchanged. Kill in ADD → `result_o` and `overflow_o` unchanged, no pulse. Kill in DONE → the pulse still occurs.
- **Reset mid-op:** assert `rst_ni`=0 while in ADD → all outputs 0 immediately. The next MAC completes normally.
- **Back-to-back:** hold `mac_start_i` high continuously → a new MAC is accepted only in IDLE, so there is one result every 4 cycles with a single-cycle multiplier. A start pulse in DONE is ignored.
